// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath widths, fetch-queue depth and the
// layout of one buffered fetch entry.
package cpu_defs;

    localparam int INST_W   = 32;
    localparam int ADDR_W   = 32;
    localparam int FQ_DEPTH = 4;
    localparam int ENTRY_W  = ADDR_W + INST_W;

    // One fetched instruction with its address; pc occupies the upper half.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Build a fetch entry from its two halves.
    function automatic fetch_entry_t make_entry(input logic [ADDR_W-1:0] pc,
                                                input logic [INST_W-1:0] inst);
        fetch_entry_t e;
        e.pc   = pc;
        e.inst = inst;
        return e;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Storage array for the fetch queue: one synchronous write port and one
// asynchronous read port. Reset zeroes every entry so the read port never
// presents X after reset.
module sync_fifo_mem
    import cpu_defs::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  fetch_entry_t  wdata,
    input  logic [AW-1:0] raddr,
    output fetch_entry_t  rdata
);

    fetch_entry_t mem_q [DEPTH];

    // Entry write; reset clears the whole array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: captures {pc, inst} pairs from the PC unit / ROM
// into an in-order FIFO and presents the oldest entry to decode through a
// valid/ready handshake. Full asserts fetch_stall; flush discards everything.
module inst_fetch_queue
    import cpu_defs::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_ce,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              fetch_stall,
    input  logic              flush,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          push;
    logic          pop;
    fetch_entry_t  head_entry;

    // Status is decoded from registered occupancy only, so a full queue
    // refuses a push even in a cycle where decode pops.
    assign fetch_stall = (count_q == FULL_COUNT);
    assign id_valid    = (count_q != '0);
    assign count       = count_q;

    assign push = if_ce & ~fetch_stall & ~flush;
    assign pop  = id_valid & id_ready & ~flush;

    // Next-state for pointers and occupancy; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sync_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (make_entry(if_pc, if_inst)),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    assign id_pc   = head_entry.pc;
    assign id_inst = head_entry.inst;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue. A queue-based reference model
// tracks the expected contents; outputs are sampled 1 time unit after the
// rising edge, where inputs are also driven.
module tb_inst_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_ce = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        fetch_stall;
    logic        flush = 1'b0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [AW:0] count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] mq [$];

    inst_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_ce       (if_ce),
        .if_pc       (if_pc),
        .if_inst     (if_inst),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Advance one clock and update the reference model from the rules:
    // reset/flush empty the queue, otherwise pop the head if decode takes it
    // and append the fetch if there was room before the edge.
    task automatic step();
        bit do_push, do_pop;
        do_push = if_ce && (mq.size() < DEPTH) && !flush;
        do_pop  = (mq.size() != 0) && id_ready && !flush;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({if_pc, if_inst});
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_ce = 1'b1; flush = 1'b0; id_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if_pc = $urandom; if_inst = $urandom;
            step();
            total_cnt++;
            if ({count, id_valid, fetch_stall, id_pc, id_inst} !== {3'd0, 1'b0, 1'b0, 32'd0, 32'd0})
                $display("FAIL reset: count=%0d valid=%0b stall=%0b pc=%h inst=%h required all zero",
                         count, id_valid, fetch_stall, id_pc, id_inst);
            else pass_cnt++;
        end
        rst = 1'b0; if_ce = 1'b0; if_pc = '0; if_inst = '0;
    endtask

    task automatic test_fill();
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if_ce = 1'b1; if_pc = 32'(4 * i); if_inst = 32'h2008_0000 + if_pc;
            step();
            total_cnt++;
            if ({count, id_valid, fetch_stall} !== {3'(mq.size()), mq.size() != 0, mq.size() == DEPTH})
                $display("FAIL fill_status[%0d]: count=%0d valid=%0b stall=%0b required count=%0d",
                         i, count, id_valid, fetch_stall, mq.size());
            else pass_cnt++;
        end
        if_ce = 1'b0; if_pc = '0; if_inst = '0;
        total_cnt++;
        if ({count, fetch_stall, id_pc, id_inst} !== {3'd4, 1'b1, 32'h0, 32'h2008_0000})
            $display("FAIL fill_full: count=%0d stall=%0b pc=%h inst=%h required 4 1 00000000 20080000",
                     count, fetch_stall, id_pc, id_inst);
        else pass_cnt++;
        total_cnt++;
        if (mq[DEPTH-1][63:32] !== 32'hC)
            $display("FAIL fill_model_tail: tail=%h required 0000000c", mq[DEPTH-1][63:32]);
        else pass_cnt++;
    endtask

    task automatic test_drain();
        logic [31:0] exp_pc;
        if_ce = 1'b0; if_pc = '0; id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(4 * i);
            total_cnt++;
            if ({id_valid, id_pc, id_inst} !== {1'b1, exp_pc, 32'h2008_0000 + exp_pc})
                $display("FAIL drain[%0d]: valid=%0b pc=%h inst=%h required pc=%h", i, id_valid, id_pc, id_inst, exp_pc);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if ({id_valid, count, fetch_stall} !== {1'b0, 3'd0, 1'b0})
            $display("FAIL drain_empty: valid=%0b count=%0d stall=%0b required 0 0 0", id_valid, count, fetch_stall);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [31:0] prev_pc;
        id_ready = 1'b1; if_ce = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_pc = 32'h40 + 32'(4 * i); if_inst = $urandom;
            prev_pc = if_pc;
            step();
            total_cnt++;
            if ({count, fetch_stall, id_valid, id_pc} !== {3'd1, 1'b0, 1'b1, prev_pc})
                $display("FAIL stream[%0d]: count=%0d stall=%0b valid=%0b pc=%h required 1 0 1 %h",
                         i, count, fetch_stall, id_valid, id_pc, prev_pc);
            else pass_cnt++;
        end
        if_ce = 1'b0; if_pc = '0;
        step();
    endtask

    task automatic test_flush();
        id_ready = 1'b0; if_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_pc = 32'h200 + 32'(4 * i); if_inst = $urandom;
            step();
        end
        total_cnt++;
        if (count !== 3'd3)
            $display("FAIL flush_setup: count=%0d required 3", count);
        else pass_cnt++;
        flush = 1'b1; id_ready = 1'b1; if_pc = 32'h300;
        step();
        flush = 1'b0; id_ready = 1'b0;
        total_cnt++;
        if ({count, id_valid, fetch_stall} !== {3'd0, 1'b0, 1'b0})
            $display("FAIL flush_clear: count=%0d valid=%0b stall=%0b required 0 0 0", count, id_valid, fetch_stall);
        else pass_cnt++;
        if_pc = 32'h100; if_inst = 32'h2008_0100;
        step();
        if_ce = 1'b0; if_pc = '0;
        total_cnt++;
        if ({count, id_valid, id_pc, id_inst} !== {3'd1, 1'b1, 32'h100, 32'h2008_0100})
            $display("FAIL flush_repush: count=%0d valid=%0b pc=%h inst=%h required 1 1 00000100 20080100",
                     count, id_valid, id_pc, id_inst);
        else pass_cnt++;
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int pushed = 0, popped = 0, cyc = 0;
        logic [31:0] next_pc = 32'h1000;
        while (popped < 9 && cyc < 200) begin
            if_ce    = (pushed < 9);
            if_pc    = if_ce ? next_pc : 32'h0;
            if_inst  = $urandom;
            id_ready = $urandom_range(0, 1);
            if (id_valid && id_ready) begin
                total_cnt++;
                if ({id_pc, id_inst} !== mq[0])
                    $display("FAIL wrap_pop[%0d]: got %h_%h required %h", popped, id_pc, id_inst, mq[0]);
                else pass_cnt++;
                popped++;
            end
            if (if_ce && mq.size() < DEPTH) begin
                pushed++;
                next_pc += 32'd4;
            end
            step();
            cyc++;
        end
        if_ce = 1'b0; if_pc = '0; id_ready = 1'b0;
        total_cnt++;
        if (popped != 9 || count !== 3'd0)
            $display("FAIL wrap_done: popped=%0d count=%0d required 9 0 within 200 cycles", popped, count);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            if_ce    = $urandom_range(0, 3) != 0;
            id_ready = $urandom_range(0, 2) != 0;
            if_pc    = if_ce ? $urandom : 32'h0;
            if_inst  = $urandom;
            step();
            total_cnt++;
            if ({count, id_valid, fetch_stall} !== {3'(mq.size()), mq.size() != 0, mq.size() == DEPTH})
                $display("FAIL random_status[%0d]: count=%0d valid=%0b stall=%0b required count=%0d",
                         i, count, id_valid, fetch_stall, mq.size());
            else pass_cnt++;
            if (mq.size() != 0) begin
                total_cnt++;
                if ({id_pc, id_inst} !== mq[0])
                    $display("FAIL random_head[%0d]: got %h_%h required %h", i, id_pc, id_inst, mq[0]);
                else pass_cnt++;
            end
        end
        rst = 1'b0; flush = 1'b0; if_ce = 1'b0; id_ready = 1'b0; if_pc = '0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_flush();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction fetch queue between the program counter / instruction ROM and the decode stage. Each cycle the PC unit presents an address with its chip enable, and the ROM returns the matching instruction word in the same cycle. This block captures each address/instruction pair into a small in-order FIFO and presents the oldest entry to decode through a valid/ready handshake. It signals back-pressure to the PC unit and discards all buffered entries on a control-flow flush.

## Interface
Parameters:
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- AW, 2: pointer width; log2(DEPTH).

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst, in, 1: reset, synchronous, active-high.
- if_ce, in, 1: PC chip enable; 1 = if_pc/if_inst is a valid fetch.
- if_pc, in, 32: fetch address.
- if_inst, in, 32: instruction word for if_pc, same cycle.
- fetch_stall, out, 1: queue full; the PC unit must hold its address.
- flush, in, 1: branch/jump redirect; discard all entries.
- id_valid, out, 1: head entry valid.
- id_ready, in, 1: decode accepts the head entry this cycle.
- id_pc, out, 32: head entry address.
- id_inst, out, 32: head entry instruction.
- count, out, AW+1: current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × 64-bit entries {pc, inst}, plus a write pointer, a read pointer and an occupancy counter. Pointers wrap modulo DEPTH.
- Push condition: push = if_ce & ~fetch_stall & ~flush.
  - Writes {if_pc, if_inst} at the write pointer.
  - Advances the write pointer.
- Pop condition: pop = id_valid & id_ready & ~flush.
  - Advances the read pointer.
- Counter update: count_next = count + push − pop. Simultaneous push and pop leaves count unchanged.
- Status outputs:
  - fetch_stall = (count == DEPTH), decoded from registered count only. There is no same-cycle pop bypass, so a full queue refuses a push even while popping.
  - id_valid = (count != 0).
  - id_pc/id_inst: combinational read of the entry at the read pointer. Don't-care when id_valid = 0, but must not be X after reset.
- Flush:
  - Highest priority.
  - Next edge: both pointers return to 0 and count returns to 0.
  - A push or pop requested in the same cycle is ignored.
  - Entry contents are not cleared.
- Reset:
  - Clears both pointers and count, and zeroes all entries.
  - Reset mid-operation drops all in-flight entries with no partial update.
- Ordering: strictly in-order; there is no reordering or duplication.

## Timing
- Reset values: id_valid = 0, id_pc = 0, id_inst = 0, fetch_stall = 0, count = 0.
- Latency: a push at edge N makes the entry visible on id_* after edge N (one cycle later), when the queue was empty.
- No combinational path from if_* to id_*.
- fetch_stall depends only on registered state and asserts the cycle after the queue fills.
- Handshake rules:
  - Decode samples id_* when id_valid & id_ready.
  - id_* stays stable while id_valid = 1 and id_ready = 0.
  - id_ready may be high while id_valid = 0; no pop occurs.
- After flush at edge N: id_valid = 0 and fetch_stall = 0 in the following cycle. The first post-flush push is accepted at edge N+1.
- if_ce = 0: no push. The PC unit holds address 0 during this time.

## Structure
- Shared package (cpu_defs): INST_W = 32, ADDR_W = 32, FQ_DEPTH = 4, and the fetch-entry struct/concatenation layout {pc, inst}.
- One natural sub-module: sync_fifo_mem, the DEPTH × 64 storage array with one write port and one asynchronous read port. Pointer, count and flush logic stay in inst_fetch_queue.

## Test plan
- Reset: assert rst for 2 cycles with if_ce = 1.
  - Required: count = 0, id_valid = 0, id_pc = 0, fetch_stall = 0 throughout.
- Fill and back-pressure: hold id_ready = 0 and drive pc = 0x0, 0x4, 0x8, 0xC, 0x10 with inst = 0x20080000 + pc.
  - Required: count reaches 4 and fetch_stall = 1.
  - 0x10 is not stored.
  - id_pc = 0x0.
- Drain order: from full, set id_ready = 1 with if_ce = 0.
  - Required: id_pc sequence 0x0, 0x4, 0x8, 0xC.
  - Then id_valid = 0 and count = 0.
- Streaming: hold id_ready = 1 and if_ce = 1 for 10 cycles with pc incrementing by 4 from 0x40.
  - Required: count stays at 1 after the first edge.
  - id_pc lags if_pc by exactly one cycle.
  - No stall.
- Flush: with count = 3, assert flush together with if_ce = 1 and id_ready = 1.
  - Required: the next cycle has count = 0 and id_valid = 0.
  - The same-cycle push and pop are ignored.
  - A following push of pc = 0x100 appears as id_pc = 0x100.
- Wrap-around: perform 9 push/pop pairs at DEPTH = 4 with random id_ready.
  - Required: the scoreboard matches every {pc, inst} in order, with no loss or duplication across the pointer wrap.
